// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions. This package provides the parity mode
//            constants, the receiver state encoding and the bit-timing helper
//            used by the receiver and by the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode selectors
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Receiver frame-tracking states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Core clocks per line bit. The result is truncated by integer division,
    // so the accumulated drift over one frame must stay inside half a bit.
    function automatic int calc_cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a single asynchronous input. Its reset
//            value is a parameter so that an idle-high line does not produce
//            a false edge when the block leaves reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: the first stage may go metastable, and the second stage gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Parametrised UART receiver. It supports a 5..9-bit payload,
//            no/odd/even parity and 1 or 2 stop bits. It checks the start,
//            parity and stop bits of each frame, and hands each character and
//            its error flags to the consumer through a one-entry ready/valid
//            buffer. It keeps a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic                 busy
);

    localparam int CYCLES_PER_BIT = calc_cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_POINT   = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BIT_W          = 4;

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);
    localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP  = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD    = (PARITY == PARITY_ODD);
    localparam bit               HAS_PARITY = (PARITY != PARITY_NONE);

    // Reject unsupported frame formats at elaboration
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (CYCLES_PER_BIT < 2) begin : g_bad_baud
        $error("uart_rx_cfg: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    logic                 rx_s;
    logic                 rx_prev_q;
    rx_state_t            state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_pend_q;
    logic                 frm_err_pend_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_out_valid_q;
    logic                 parity_error_q;
    logic                 frame_error_q;
    logic                 overrun_q;

    logic                 sample_now_d;
    logic                 fall_edge_d;
    logic                 parity_err_d;
    logic                 frame_err_d;
    logic                 can_load_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    // Edge register: holds the previous synchronised line level for start-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    // Per-cycle decisions derived from the current line sample and state
    always_comb begin
        sample_now_d = (clk_cnt_q == SAMPLE_CNT);
        fall_edge_d  = rx_prev_q & ~rx_s;
        // The XOR of the payload and the received parity bit is 1 for odd parity and 0 for even parity
        parity_err_d = (^{shift_q, rx_s}) ^ PAR_ODD;
        frame_err_d  = frm_err_pend_q | ~rx_s;
        can_load_d   = ~data_out_valid_q | data_out_ready;
    end

    // Frame FSM, bit timing, output buffer and overrun tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= RX_IDLE;
            clk_cnt_q        <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            par_err_pend_q   <= 1'b0;
            frm_err_pend_q   <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            parity_error_q   <= 1'b0;
            frame_error_q    <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            // Bit timer free-runs while a frame is in progress. State changes
            // happen at the sample point, so the next sample is one bit later.
            if (state_q == RX_IDLE || clk_cnt_q == CNT_MAX) begin
                clk_cnt_q <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end

            // A consumer handshake empties the buffer. A load later in this block takes priority.
            if (data_out_valid_q && data_out_ready) begin
                data_out_valid_q <= 1'b0;
            end

            // Clear request. A new overrun later in this block takes priority.
            if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                RX_IDLE: begin
                    if (fall_edge_d) begin
                        state_q        <= RX_START;
                        par_err_pend_q <= 1'b0;
                        frm_err_pend_q <= 1'b0;
                    end
                end

                RX_START: begin
                    if (sample_now_d) begin
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end

                RX_DATA: begin
                    if (sample_now_d) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            state_q   <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                RX_PARITY: begin
                    if (sample_now_d) begin
                        par_err_pend_q <= parity_err_d;
                        bit_cnt_q      <= '0;
                        state_q        <= RX_STOP;
                    end
                end

                RX_STOP: begin
                    if (sample_now_d) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            // Last stop bit: deliver the character, then re-arm so the next start edge can be caught
                            state_q <= RX_IDLE;
                            if (can_load_d) begin
                                data_out_q       <= shift_q;
                                data_out_valid_q <= 1'b1;
                                parity_error_q   <= par_err_pend_q;
                                frame_error_q    <= frame_err_d;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frm_err_pend_q <= frame_err_d;
                            bit_cnt_q      <= bit_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign parity_error   = parity_error_q;
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;
    assign busy           = (state_q != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Testbench for uart_rx_cfg. Instance A uses 8N1 and instance B
//            uses 7 data bits, even parity and 2 stop bits. Frames are
//            built from a bit-level view of the line. The expected
//            characters are queued when each frame is sent and compared by
//            per-instance monitors at each consumer handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int CPB    = CLK_HZ / BAUD;   // 434
    // Start edge to valid for 8N1: sync(2) + edge(1) + 9 bits + half bit + 1
    localparam int LAT_8N1 = 2 + 1 + 9 * CPB + CPB / 2 + 1;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals (8N1)
    logic       rst_a, rx_a, ready_a, clr_a;
    logic [7:0] dout_a;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
    // Instance B signals (7E2)
    logic       rst_b, rx_b, ready_b, clr_b;
    logic [6:0] dout_b;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    uart_rx_cfg #(
        .CLOCK_FREQ (CLK_HZ), .BAUD_RATE (BAUD),
        .DATA_BITS (8), .PARITY (0), .STOP_BITS (1)
    ) dut_a (
        .clk (clk), .rst (rst_a), .serial_in (rx_a),
        .data_out (dout_a), .data_out_valid (valid_a), .data_out_ready (ready_a),
        .parity_error (perr_a), .frame_error (ferr_a), .overrun (ovr_a),
        .clear_overrun (clr_a), .busy (busy_a)
    );

    uart_rx_cfg #(
        .CLOCK_FREQ (CLK_HZ), .BAUD_RATE (BAUD),
        .DATA_BITS (7), .PARITY (2), .STOP_BITS (2)
    ) dut_b (
        .clk (clk), .rst (rst_b), .serial_in (rx_b),
        .data_out (dout_b), .data_out_valid (valid_b), .data_out_ready (ready_b),
        .parity_error (perr_b), .frame_error (ferr_b), .overrun (ovr_b),
        .clear_overrun (clr_b), .busy (busy_b)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   a_pops = 0;
    int unsigned a_start_cyc = 0;
    int unsigned a_valid_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    // Check the outputs of instance A one cycle after a reset pulse
    task automatic pulse_reset_a();
        rst_a = 1'b0;
        tick(1);
        rst_a = 1'b1;
        chk("rst_mid_valid",   valid_a, 0);
        chk("rst_mid_data",    dout_a,  0);
        chk("rst_mid_perr",    perr_a,  0);
        chk("rst_mid_ferr",    ferr_a,  0);
        chk("rst_mid_overrun", ovr_a,   0);
        chk("rst_mid_busy",    busy_a,  0);
    endtask

    // Send one frame. A stop bit given as 0 is held low for the first three
    // quarters of the bit, past the receiver sample point, and then released
    // high. The release creates a real falling edge before the next start bit.
    task automatic send(input int which, input logic [8:0] data, input bit flip_par,
                        input logic [1:0] stops, input int rst_bit, input bit deliver);
        int         nb, pm, ns, ones;
        logic       p, ferr;
        logic [8:0] mask;
        exp_t       e;
        nb   = (which == 0) ? 8 : 7;
        pm   = (which == 0) ? 0 : 2;
        ns   = (which == 0) ? 1 : 2;
        mask = 9'((1 << nb) - 1);
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(data[i]);
        // Correct parity bit: brings the count of ones to odd (mode 1) or even (mode 2)
        p = (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        p = p ^ flip_par;
        ferr = 1'b0;
        for (int i = 0; i < ns; i++) if (stops[i] == 1'b0) ferr = 1'b1;
        if (deliver) begin
            e.data = data & mask;
            e.perr = (pm != 0) && flip_par;
            e.ferr = ferr;
            if (which == 0) q_a.push_back(e);
            else            q_b.push_back(e);
        end
        drive(which, 1'b0);
        if (which == 0) a_start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < nb; i++) begin
            drive(which, data[i]);
            if (i == rst_bit && which == 0) begin
                tick(CPB / 2);
                pulse_reset_a();
                tick(CPB - CPB / 2 - 1);
            end else begin
                tick(CPB);
            end
        end
        if (pm != 0) begin
            drive(which, p);
            tick(CPB);
        end
        for (int i = 0; i < ns; i++) begin
            if (stops[i]) begin
                drive(which, 1'b1);
                tick(CPB);
            end else begin
                drive(which, 1'b0);
                tick(CPB * 3 / 4);
                drive(which, 1'b1);
                tick(CPB - CPB * 3 / 4);
            end
        end
        drive(which, 1'b1);
    endtask

    // Monitor A: every handshake must match the oldest expected character
    exp_t ea;
    always @(negedge clk) begin
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            a_pops++;
            a_valid_cyc = cyc;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_char actual=%0h required=no_output", dout_a);
            end else begin
                ea = q_a.pop_front();
                chk("a_data",         dout_a, ea.data);
                chk("a_parity_error", perr_a, ea.perr);
                chk("a_frame_error",  ferr_a, ea.ferr);
            end
        end
    end

    // Monitor B
    exp_t eb;
    always @(negedge clk) begin
        if (valid_b === 1'b1 && ready_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_char actual=%0h required=no_output", dout_b);
            end else begin
                eb = q_b.pop_front();
                chk("b_data",         dout_b, eb.data);
                chk("b_parity_error", perr_b, eb.perr);
                chk("b_frame_error",  ferr_b, eb.ferr);
            end
        end
    end

    initial begin
        int pops0, lat;
        rst_a = 1'b0; rst_b = 1'b0;
        rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        tick(3);
        chk("rst_a_valid",   valid_a, 0);
        chk("rst_a_data",    dout_a,  0);
        chk("rst_a_flags",   {perr_a, ferr_a}, 0);
        chk("rst_a_overrun", ovr_a,   0);
        chk("rst_a_busy",    busy_a,  0);
        chk("rst_b_valid",   valid_b, 0);
        chk("rst_b_busy",    busy_b,  0);
        chk("rst_b_flags",   {perr_b, ferr_b, ovr_b}, 0);
        rst_a = 1'b1; rst_b = 1'b1;
        tick(5);

        fork
            begin : thread_a
                // 8N1 basic character, latency and single-cycle valid
                pops0 = a_pops;
                send(0, 9'h61, 1'b0, 2'b11, -1, 1'b1);
                chk("a_one_delivery", a_pops - pops0, 1);
                lat = int'(a_valid_cyc - a_start_cyc);
                checks++;
                if (lat < LAT_8N1 - 2 || lat > 4345 + 2) begin
                    errors++;
                    $display("FAIL a_latency actual=%0d required=%0d..%0d", lat, LAT_8N1 - 2, 4347);
                end
                chk("a_valid_one_cycle", valid_a, 0);
                tick(20);

                // Low stop bit, then a clean character sent back to back
                send(0, 9'h03e, 1'b0, 2'b10, -1, 1'b1);
                send(0, 9'h020, 1'b0, 2'b11, -1, 1'b1);
                tick(20);

                // Glitch shorter than half a bit is rejected as a false start
                rx_a = 1'b0;
                tick(50);
                chk("glitch_busy_during", busy_a, 1);
                tick(50);
                rx_a = 1'b1;
                tick(140);
                chk("glitch_busy_after", busy_a, 0);
                chk("glitch_no_valid",   valid_a, 0);
                tick(20);

                // Overrun: the second character is dropped while the buffer is full
                ready_a = 1'b0;
                send(0, 9'h031, 1'b0, 2'b11, -1, 1'b1);
                send(0, 9'h035, 1'b0, 2'b11, -1, 1'b0);
                tick(5);
                chk("ovr_set",        ovr_a,   1);
                chk("ovr_valid_held", valid_a, 1);
                chk("ovr_data_kept",  dout_a,  8'h31);
                ready_a = 1'b1;
                tick(2);
                chk("ovr_valid_drop", valid_a, 0);
                chk("ovr_data_hold",  dout_a,  8'h31);
                chk("ovr_sticky",     ovr_a,   1);
                clr_a = 1'b1;
                tick(1);
                clr_a = 1'b0;
                chk("ovr_cleared",    ovr_a,   0);
                tick(20);

                // Reset during data bit 6 of 0xca. The remaining bits are all
                // high, so the abandoned frame cannot retrigger the receiver.
                send(0, 9'h0ca, 1'b0, 2'b11, 6, 1'b0);
                tick(20);
                send(0, 9'h0fe, 1'b0, 2'b11, -1, 1'b1);
                tick(10);

                // Random characters with occasional bad stop bits
                for (int k = 0; k < 5; k++) begin
                    send(0, 9'($urandom_range(0, 255)), 1'b0,
                         ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, -1, 1'b1);
                    tick($urandom_range(1, 20));
                end
            end
            begin : thread_b
                // 7E2: correct parity bit, then an inverted parity bit
                send(1, 9'h035, 1'b0, 2'b11, -1, 1'b1);
                tick(10);
                send(1, 9'h035, 1'b1, 2'b11, -1, 1'b1);
                tick(10);
                for (int k = 0; k < 3; k++) begin
                    send(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), -1, 1'b1);
                    tick($urandom_range(1, 20));
                end
            end
        join

        for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) tick(1);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
